led_sequencer: RTL and testbench



---
 rtl/led_seq_pkg.sv | 32 +++
 rtl/led_prescaler.sv | 29 ++
 rtl/led_sequencer.sv | 103 ++++++++++
 tb/tb_led_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and pattern decode for the LED sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    CHASE  = 2'd0,
    BOUNCE = 2'd1,
    COUNT  = 2'd2,
    BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Pattern for one step; bit 0 = D1 .. bit 3 = D4.
  function automatic logic [3:0] led_pattern(input mode_e mode, input logic [31:0] step);
    logic [31:0] p;
    logic [1:0]  idx;
    p           = step % 32'd6;
    idx         = (p < 32'd4) ? p[1:0] : 2'(32'd6 - p);
    led_pattern = 4'b0000;
    case (mode)
      CHASE:   led_pattern = 4'b0001 << step[1:0];
      BOUNCE:  led_pattern = 4'b0001 << idx;
      COUNT:   led_pattern = step[3:0];
      BLINK:   led_pattern = step[0] ? 4'b0000 : 4'b1111;
      default: led_pattern = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler: counts 0..DIV-1 while enabled, tick on the last count.
module led_prescaler #(
  parameter int DIV = 1500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt;

  // Tick only when counting, so a held (paused) count never advances a step.
  assign tick = en && (pcnt == LAST);

  // Counter: clear wins over enable, wraps on tick.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// Timed LED pattern sequencer for D1..D4 with D5 as ready indicator.
// Optional macro LED_SEQ_PAUSE_EN adds a pause input that freezes a run.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int DIV     = 1500000,
  parameter int N_STEPS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
`ifdef LED_SEQ_PAUSE_EN
  input  logic       pause,
`endif
  output logic       busy,
  output logic       done,
  output logic       D1,
  output logic       D2,
  output logic       D3,
  output logic       D4,
  output logic       D5
);

  localparam int SW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(N_STEPS - 1);

  state_e        state;
  mode_e         mode_q;
  logic [SW-1:0] step;
  logic [3:0]    leds;
  logic          busy_q;
  logic          done_q;
  logic          run_en;
  logic          presc_clr;
  logic          tick;

`ifdef LED_SEQ_PAUSE_EN
  assign run_en = (state == RUN) && !pause;
`else
  assign run_en = (state == RUN);
`endif

  // Holding the prescaler clear while idle also clears it at the accepting edge.
  assign presc_clr = (state == IDLE);

  led_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (run_en),
    .tick (tick)
  );

  // Sequencer FSM; LED outputs are loaded with the pattern of the next step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= CHASE;
      step   <= '0;
      leds   <= 4'b0000;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            mode_q <= mode_e'(mode);
            step   <= '0;
            leds   <= led_pattern(mode_e'(mode), 32'd0);
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            if (step == LAST_STEP) begin
              state  <= IDLE;
              step   <= '0;
              leds   <= 4'b0000;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              step <= step + 1'b1;
              leds <= led_pattern(mode_q, 32'(step) + 32'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D1   = leds[0];
  assign D2   = leds[1];
  assign D3   = leds[2];
  assign D4   = leds[3];
  assign D5   = ~busy_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: driver pushes expected outputs, monitor compares.
module tb_led_sequencer;

  localparam int DIV     = 4;
  localparam int N_STEPS = 6;
`ifdef LED_SEQ_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] leds;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       pause;
  logic       busy, done, D1, D2, D3, D4, D5;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state: whether a run is active, counted cycles, latched mode.
  bit m_active = 1'b0;
  int m_k      = 0;
  int m_mode   = 0;

  always #5 clk = ~clk;

  led_sequencer #(.DIV(DIV), .N_STEPS(N_STEPS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
`ifdef LED_SEQ_PAUSE_EN
    .pause (pause),
`endif
    .busy  (busy),
    .done  (done),
    .D1    (D1),
    .D2    (D2),
    .D3    (D3),
    .D4    (D4),
    .D5    (D5)
  );

  function automatic logic [3:0] ref_pat(input int md, input int s);
    int bounce [6];
    bounce = '{0, 1, 2, 3, 2, 1};
    case (md)
      0:       return 4'(1 << (s % 4));
      1:       return 4'(1 << bounce[s % 6]);
      2:       return 4'(s % 16);
      default: return ((s % 2) == 0) ? 4'hF : 4'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  // One clock cycle of stimulus; the model predicts the outputs seen after the edge.
  task automatic step_cyc(input bit r, input bit s, input int md, input bit p);
    exp_t e;
    rst   = r;
    start = s;
    mode  = 2'(md);
    pause = p;
    if (r) begin
      m_active = 1'b0;
      e = '{busy: 1'b0, done: 1'b0, leds: 4'h0};
    end else if (!m_active) begin
      if (s) begin
        m_active = 1'b1;
        m_k      = 0;
        m_mode   = md;
        e = '{busy: 1'b1, done: 1'b0, leds: ref_pat(md, 0)};
      end else begin
        e = '{busy: 1'b0, done: 1'b0, leds: 4'h0};
      end
    end else begin
      if (!(p && PAUSE_ON)) m_k++;
      if (m_k == N_STEPS * DIV) begin
        m_active = 1'b0;
        e = '{busy: 1'b0, done: 1'b1, leds: 4'h0};
      end else begin
        e = '{busy: 1'b1, done: 1'b0, leds: ref_pat(m_mode, m_k / DIV)};
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: every cycle after the edge, compare DUT outputs to the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("busy", {3'b0, busy}, {3'b0, e.busy});
      chk("done", {3'b0, done}, {3'b0, e.done});
      chk("leds", {D4, D3, D2, D1}, e.leds);
      chk("d5",   {3'b0, D5}, {3'b0, ~e.busy});
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; pause = 1'b0;

    // Reset then idle.
    step_cyc(1, 0, 0, 0);
    step_cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step_cyc(0, 0, 0, 0);

    // One run per mode; start during a run (incl. the cycle before done) is ignored.
    for (int md = 0; md < 4; md++) begin
      step_cyc(0, 1, md, 0);
      for (int i = 1; i < 30; i++)
        step_cyc(0, (md == 3 && i == 6) || (md == 0 && i == 24), 0, 0);
    end

    // Reset mid-run: no done for that run.
    step_cyc(0, 1, 2, 0);
    for (int i = 1; i < 10; i++) step_cyc(0, 0, 0, 0);
    step_cyc(1, 0, 0, 0);
    for (int i = 0; i < 30; i++) step_cyc(0, 0, 0, 0);

    // Start held high: back-to-back runs with a one-cycle gap.
    for (int i = 0; i < 60; i++) step_cyc(0, 1, 1, 0);
    for (int i = 0; i < 30; i++) step_cyc(0, 0, 0, 0);

    // Pause for 7 cycles mid-run (freezes only when the feature is built in).
    step_cyc(0, 1, 0, 1);
    for (int i = 1; i < 8; i++) step_cyc(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step_cyc(0, 0, 0, 1);
    for (int i = 0; i < 30; i++) step_cyc(0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++)
      step_cyc(($urandom % 100) == 0, ($urandom % 6) == 0,
               int'($urandom % 4), ($urandom % 4) == 0);
    for (int i = 0; i < 30; i++) step_cyc(0, 0, 0, 0);

    chk("queue_drained", 4'(exp_q.size()), 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
